r4_butterfly: RTL and testbench

//  Pipelined radix-4 butterfly, first stage of the 16-point FFT datapath, directly downstream of the

---
 rtl/fft_pkg.sv | 60 ++++++
 rtl/r4_scale.sv | 12 +
 rtl/r4_butterfly.sv | 112 +++++++++++
 tb/tb_r4_butterfly.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types, sample packing helpers and output scaling.
// Build option R4_ROUND_EN selects round-half-up with saturation instead of floor.
package fft_pkg;

    localparam int CW   = 17;
    localparam int NGRP = 4;
    localparam int SW   = 2 * CW;
    localparam int GW   = $clog2(NGRP);

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [CW:0] re;
        logic signed [CW:0] im;
    } cplx1_t;

    typedef struct packed {
        logic signed [CW+1:0] re;
        logic signed [CW+1:0] im;
    } cplx2_t;

    function automatic cplx_t unpack_smp(input logic [4*SW-1:0] w,
                                         input int k);
        return cplx_t'(w[k*SW +: SW]);
    endfunction

    function automatic logic [4*SW-1:0] pack_smp(input cplx_t s3,
                                                 input cplx_t s2,
                                                 input cplx_t s1,
                                                 input cplx_t s0);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic signed [CW:0] sx1(input logic signed [CW-1:0] v);
        return {v[CW-1], v};
    endfunction

    function automatic logic signed [CW+1:0] sx2(input logic signed [CW:0] v);
        return {v[CW], v};
    endfunction

    function automatic logic signed [CW-1:0] scale(input logic signed [CW+1:0] v);
`ifdef R4_ROUND_EN
        logic [CW+2:0] r;
        logic [CW:0]   t;
        r = {v[CW+1], v} + (CW+3)'(2);
        t = r[CW+2:2];
        // Only +max can round past the positive rail, but clamp both ways.
        if (t[CW] != t[CW-1])
            return t[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
        return t[CW-1:0];
`else
        return v[CW+1:2];
`endif
    endfunction

endpackage

// File: rtl/r4_scale.sv
// Scales one CW+2 bit butterfly component back to CW bits.
// Rounding/saturation follows the R4_ROUND_EN build option.
module r4_scale
    import fft_pkg::*;
(
    input  logic signed [CW+1:0] v_i,
    output logic signed [CW-1:0] s_o
);

    assign s_o = scale(v_i);

endmodule

// File: rtl/r4_butterfly.sv
// Two-stage pipelined radix-4 butterfly with 1/4 scaling and frame tagging.
// Build option R4_ROUND_EN selects rounded, saturated scaling.
module r4_butterfly
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8*CW-1:0] data_in,
    input  logic            in_flag,
    output logic [8*CW-1:0] data_out,
    output logic            out_valid,
    output logic [GW-1:0]   out_grp,
    output logic            out_last
);

    logic [GW-1:0]   cnt_q, cnt_d;
    cplx_t           x [4];
    cplx1_t          a_d, b_d, c_d, d_d;
    cplx1_t          a_q, b_q, c_q, d_q;
    logic            va_q;
    logic [GW-1:0]   ga_q;
    cplx2_t          y [4];
    logic signed [CW+1:0] full [8];
    logic signed [CW-1:0] sc [8];
    cplx_t           ys [4];
    logic [8*CW-1:0] data_d, data_q;
    logic            vb_q, lb_q;
    logic [GW-1:0]   gb_q;

    assign cnt_d = (cnt_q == GW'(NGRP-1)) ? '0 : cnt_q + GW'(1);

    always_comb begin
        for (int k = 0; k < 4; k++) x[k] = unpack_smp(data_in, k);
        a_d.re = sx1(x[0].re) + sx1(x[2].re);
        a_d.im = sx1(x[0].im) + sx1(x[2].im);
        b_d.re = sx1(x[0].re) - sx1(x[2].re);
        b_d.im = sx1(x[0].im) - sx1(x[2].im);
        c_d.re = sx1(x[1].re) + sx1(x[3].re);
        c_d.im = sx1(x[1].im) + sx1(x[3].im);
        d_d.re = sx1(x[1].re) - sx1(x[3].re);
        d_d.im = sx1(x[1].im) - sx1(x[3].im);
    end

    // X1 = b - j*d, X3 = b + j*d
    always_comb begin
        y[0].re = sx2(a_q.re) + sx2(c_q.re);
        y[0].im = sx2(a_q.im) + sx2(c_q.im);
        y[2].re = sx2(a_q.re) - sx2(c_q.re);
        y[2].im = sx2(a_q.im) - sx2(c_q.im);
        y[1].re = sx2(b_q.re) + sx2(d_q.im);
        y[1].im = sx2(b_q.im) - sx2(d_q.re);
        y[3].re = sx2(b_q.re) - sx2(d_q.im);
        y[3].im = sx2(b_q.im) + sx2(d_q.re);
        for (int k = 0; k < 4; k++) begin
            full[2*k+1] = y[k].re;
            full[2*k]   = y[k].im;
        end
    end

    for (genvar j = 0; j < 8; j++) begin : g_sc
        r4_scale u_sc (
            .v_i (full[j]),
            .s_o (sc[j])
        );
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ys[k].re = sc[2*k+1];
            ys[k].im = sc[2*k];
        end
        data_d = pack_smp(ys[3], ys[2], ys[1], ys[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            va_q   <= 1'b0;
            ga_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            vb_q   <= 1'b0;
            lb_q   <= 1'b0;
            gb_q   <= '0;
            data_q <= '0;
        end else begin
            va_q <= in_flag;
            if (in_flag) begin
                a_q   <= a_d;
                b_q   <= b_d;
                c_q   <= c_d;
                d_q   <= d_d;
                ga_q  <= cnt_q;
                cnt_q <= cnt_d;
            end
            vb_q <= va_q;
            lb_q <= va_q && (ga_q == GW'(NGRP-1));
            if (va_q) begin
                data_q <= data_d;
                gb_q   <= ga_q;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = vb_q;
    assign out_grp   = gb_q;
    assign out_last  = lb_q;

endmodule

// File: tb/tb_r4_butterfly.sv
// Directed self-checking bench for r4_butterfly.
// Expected values are hand-computed; R4_ROUND_EN selects the rounded set.
module tb_r4_butterfly;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [135:0] data_in = '0;
    logic         in_flag = 1'b0;
    logic [135:0] data_out;
    logic         out_valid;
    logic [1:0]   out_grp;
    logic         out_last;

    int errs = 0;
    int checks = 0;
    int egrp = 0;

    r4_butterfly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_flag   (in_flag),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_grp   (out_grp),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] cp(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return {r[16:0], i[16:0]};
    endfunction

    function automatic logic [135:0] w4(input logic [33:0] s3, input logic [33:0] s2,
                                        input logic [33:0] s1, input logic [33:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sends one isolated group and checks latency, data and tags.
    task automatic one(input string tag, input logic [135:0] din, input logic [135:0] exp);
        @(negedge clk);
        in_flag = 1'b1;
        data_in = din;
        @(negedge clk);
        in_flag = 1'b0;
        data_in = '0;
        chk({tag, "_early"}, 136'(out_valid), 136'(0));
        @(negedge clk);
        chk({tag, "_valid"}, 136'(out_valid), 136'(1));
        chk({tag, "_data"}, data_out, exp);
        chk({tag, "_grp"}, 136'(out_grp), 136'(egrp));
        chk({tag, "_last"}, 136'(out_last), 136'(egrp == 3));
        egrp = (egrp + 1) % 4;
        @(negedge clk);
        chk({tag, "_drop"}, 136'(out_valid), 136'(0));
        chk({tag, "_droplast"}, 136'(out_last), 136'(0));
    endtask

    initial begin
        logic [135:0] e;
        #2;
        chk("rst_valid", 136'(out_valid), 136'(0));
        chk("rst_last", 136'(out_last), 136'(0));
        chk("rst_grp", 136'(out_grp), 136'(0));
        chk("rst_data", data_out, 136'(0));
        @(negedge clk);
        rst_n = 1'b1;

        one("impulse", w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(100, 0)),
            w4(cp(25, 0), cp(25, 0), cp(25, 0), cp(25, 0)));
        one("dc", w4(cp(4, 0), cp(4, 0), cp(4, 0), cp(4, 0)),
            w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(4, 0)));
        one("jx1", w4(cp(0, 0), cp(0, 0), cp(0, 4), cp(0, 0)),
            w4(cp(-1, 0), cp(0, -1), cp(1, 0), cp(0, 1)));
`ifdef R4_ROUND_EN
        e = w4(cp(1, 0), cp(1, 0), cp(1, 0), cp(1, 0));
`else
        e = w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(0, 0));
`endif
        one("rnd_pos", w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(2, 0)), e);
`ifdef R4_ROUND_EN
        e = w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(0, 0));
`else
        e = w4(cp(-1, 0), cp(-1, 0), cp(-1, 0), cp(-1, 0));
`endif
        one("rnd_neg", w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(-2, 0)), e);
`ifdef R4_ROUND_EN
        e = w4(cp(0, 0), cp(0, 0), cp(65535, 0), cp(0, 0));
`else
        e = w4(cp(0, 0), cp(-1, 0), cp(65535, 0), cp(-1, -1));
`endif
        one("ext_max", w4(cp(0, -65536), cp(-65536, 0), cp(0, 65535), cp(65535, 0)), e);
        one("ext_min", w4(cp(-65536, -65536), cp(-65536, -65536),
                          cp(-65536, -65536), cp(-65536, -65536)),
            w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(-65536, -65536)));

        // Fresh counter for framing
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        egrp = 0;

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (i >= 2 && i < 6) begin
                    int v;
                    v = f * 4 + (i - 2) + 1;
                    chk($sformatf("frm%0d_c%0d_valid", f, i), 136'(out_valid), 136'(1));
                    chk($sformatf("frm%0d_c%0d_grp", f, i), 136'(out_grp), 136'(i - 2));
                    chk($sformatf("frm%0d_c%0d_last", f, i), 136'(out_last), 136'(i == 5));
                    chk($sformatf("frm%0d_c%0d_data", f, i), data_out,
                        w4(cp(v, 0), cp(v, 0), cp(v, 0), cp(v, 0)));
                end else begin
                    chk($sformatf("frm%0d_c%0d_idle", f, i), 136'(out_valid), 136'(0));
                    chk($sformatf("frm%0d_c%0d_idlelast", f, i), 136'(out_last), 136'(0));
                end
                in_flag = (i < 4);
                data_in = (i < 4) ? w4(cp(0, 0), cp(0, 0), cp(0, 0),
                                       cp(4 * (f * 4 + i + 1), 0)) : '0;
            end
        end

        // Mid-frame async reset after groups 0 and 1 accepted
        @(negedge clk);
        in_flag = 1'b1;
        data_in = w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(40, 0));
        @(negedge clk);
        @(negedge clk);
        in_flag = 1'b0;
        data_in = '0;
        chk("mrst_pre_valid", 136'(out_valid), 136'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 136'(out_valid), 136'(0));
        chk("mrst_grp", 136'(out_grp), 136'(0));
        chk("mrst_data", data_out, 136'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_stale%0d", i), 136'(out_valid), 136'(0));
        end
        egrp = 0;
        one("mrst_next", w4(cp(0, 0), cp(0, 0), cp(0, 0), cp(8, 0)),
            w4(cp(2, 0), cp(2, 0), cp(2, 0), cp(2, 0)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
